// File: rtl/nv_slcg_en_ctrl_if.sv
// Wake handshake between a client that needs the gated clock and the SLCG enable controller.
// The client drives wake_req; the controller answers with wake_ack once the clock is running.
interface nv_slcg_en_ctrl_if;
    logic wake_req;
    logic wake_ack;

    modport master (
        output wake_req,
        input  wake_ack
    );

    modport slave (
        input  wake_req,
        output wake_ack
    );
endinterface

// File: rtl/nv_slcg_en_ctrl.sv
// Second-level clock-gate enable controller for one gating cell (E/TE pins).
// Removes the clock after a programmable idle hysteresis; restores it on activity or wake request.
module nv_slcg_en_ctrl #(
    parameter int unsigned NUM_SRC  = 4,
    parameter int unsigned IDLE_W   = 8,
    parameter int unsigned WARM_CYC = 2
) (
    input  logic                nvdla_core_clk,
    input  logic                nvdla_core_rstn,
    input  logic                slcg_en,
    input  logic                tmc2slcg_disable_clock_gating,
    input  logic [IDLE_W-1:0]   idle_thresh,
    input  logic [NUM_SRC-1:0]  src_busy,
    nv_slcg_en_ctrl_if.slave    wake_if,
    output logic                clk_en,
    output logic                clk_te,
    output logic                gated,
    output logic [15:0]         gate_events
);

    localparam int unsigned     WarmW    = (WARM_CYC > 1) ? $clog2(WARM_CYC) : 1;
    localparam logic [WarmW-1:0] WarmLast = WarmW'(WARM_CYC - 1);

    typedef enum logic [1:0] {StRun, StCool, StOff, StWarm} state_e;

    state_e              state_q;
    logic [IDLE_W-1:0]   idle_cnt_q;
    logic [WarmW-1:0]    warm_cnt_q;
    logic                clk_en_q;
    logic                clk_te_q;
    logic                gated_q;
    logic                wake_ack_q;
    logic [15:0]         gate_events_q;
    logic [15:0]         gate_events_d;

    logic                act;
    logic                hold;
    logic [IDLE_W-1:0]   thresh_eff;
    logic                thresh_hit;
    logic                gate_evt;

    always_comb begin
        act        = (|src_busy) | wake_if.wake_req;
        hold       = ~slcg_en | tmc2slcg_disable_clock_gating;
        // A zero threshold would otherwise gate on the very first idle sample.
        thresh_eff = (idle_thresh == '0) ? IDLE_W'(1) : idle_thresh;
        thresh_hit = (idle_cnt_q >= thresh_eff);
        gate_evt   = (state_q == StCool) & ~act & ~hold & thresh_hit;

        gate_events_d = gate_events_q;
        if (gate_evt && (gate_events_q != 16'hFFFF)) begin
            gate_events_d = gate_events_q + 16'd1;
        end
    end

    always_ff @(posedge nvdla_core_clk) begin
        if (!nvdla_core_rstn) begin
            state_q       <= StRun;
            idle_cnt_q    <= '0;
            warm_cnt_q    <= '0;
            clk_en_q      <= 1'b1;
            clk_te_q      <= 1'b0;
            gated_q       <= 1'b0;
            wake_ack_q    <= 1'b0;
            gate_events_q <= '0;
        end else begin
            clk_te_q      <= tmc2slcg_disable_clock_gating;
            // Ack only from RUN, so a wake from OFF waits out the full warm-up.
            wake_ack_q    <= wake_if.wake_req & (state_q == StRun);
            gate_events_q <= gate_events_d;

            unique case (state_q)
                StRun: begin
                    clk_en_q <= 1'b1;
                    gated_q  <= 1'b0;
                    if (!act && !hold) begin
                        state_q    <= StCool;
                        idle_cnt_q <= IDLE_W'(1);
                    end
                end
                StCool: begin
                    if (act || hold) begin
                        state_q    <= StRun;
                        idle_cnt_q <= '0;
                    end else if (thresh_hit) begin
                        state_q  <= StOff;
                        clk_en_q <= 1'b0;
                        gated_q  <= 1'b1;
                    end else if (idle_cnt_q != '1) begin
                        idle_cnt_q <= idle_cnt_q + IDLE_W'(1);
                    end
                end
                StOff: begin
                    if (act || hold) begin
                        state_q    <= StWarm;
                        clk_en_q   <= 1'b1;
                        gated_q    <= 1'b0;
                        warm_cnt_q <= '0;
                    end
                end
                StWarm: begin
                    clk_en_q <= 1'b1;
                    if (warm_cnt_q == WarmLast) begin
                        state_q <= StRun;
                    end else begin
                        warm_cnt_q <= warm_cnt_q + WarmW'(1);
                    end
                end
            endcase
        end
    end

    assign clk_en           = clk_en_q;
    assign clk_te           = clk_te_q;
    assign gated            = gated_q;
    assign gate_events      = gate_events_q;
    assign wake_if.wake_ack = wake_ack_q;

endmodule

// File: tb/tb_nv_slcg_en_ctrl.sv
// Bench for nv_slcg_en_ctrl: table of per-edge vectors plus hand-built abort and saturation runs.
// Each applied vector pushes its expected outputs; they are popped and compared after the edge.
module tb_nv_slcg_en_ctrl;

    logic        clk;
    logic        rstn;
    logic        slcg_en;
    logic        tmc;
    logic [7:0]  thresh;
    logic [3:0]  busy;
    logic        clk_en;
    logic        clk_te;
    logic        gated;
    logic [15:0] gate_events;

    nv_slcg_en_ctrl_if wake_if ();

    nv_slcg_en_ctrl #(
        .NUM_SRC  (4),
        .IDLE_W   (8),
        .WARM_CYC (2)
    ) dut (
        .nvdla_core_clk                (clk),
        .nvdla_core_rstn               (rstn),
        .slcg_en                       (slcg_en),
        .tmc2slcg_disable_clock_gating (tmc),
        .idle_thresh                   (thresh),
        .src_busy                      (busy),
        .wake_if                       (wake_if.slave),
        .clk_en                        (clk_en),
        .clk_te                        (clk_te),
        .gated                         (gated),
        .gate_events                   (gate_events)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        rstn;
        logic        en;
        logic        tmc;
        logic [7:0]  th;
        logic [3:0]  busy;
        logic        req;
        logic        x_en;
        logic        x_gated;
        logic        x_ack;
        logic        x_te;
        logic [15:0] x_ev;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    function automatic void chk(string nm, string fld, logic [15:0] got, logic [15:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s.%s: got %h expected %h", nm, fld, got, exp);
        else n_pass++;
    endfunction

    function automatic vec_t mk(string nm, logic r, logic e, logic t, logic [7:0] th,
                                logic [3:0] b, logic q, logic xe, logic xg, logic xa,
                                logic xt, logic [15:0] xv);
        vec_t v;
        v.name = nm; v.rstn = r; v.en = e; v.tmc = t; v.th = th; v.busy = b; v.req = q;
        v.x_en = xe; v.x_gated = xg; v.x_ack = xa; v.x_te = xt; v.x_ev = xv;
        return v;
    endfunction

    task automatic apply(input vec_t v);
        vec_t e;
        @(negedge clk);
        rstn             = v.rstn;
        slcg_en          = v.en;
        tmc              = v.tmc;
        thresh           = v.th;
        busy             = v.busy;
        wake_if.wake_req = v.req;
        sb.push_back(v);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk(e.name, "clk_en",   {15'd0, clk_en},           {15'd0, e.x_en});
        chk(e.name, "gated",    {15'd0, gated},            {15'd0, e.x_gated});
        chk(e.name, "wake_ack", {15'd0, wake_if.wake_ack}, {15'd0, e.x_ack});
        chk(e.name, "clk_te",   {15'd0, clk_te},           {15'd0, e.x_te});
        chk(e.name, "events",   gate_events,               e.x_ev);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] ev_m;

        rstn = 1'b0; slcg_en = 1'b1; tmc = 1'b0; thresh = 8'd4; busy = '0;
        wake_if.wake_req = 1'b0;

        //                name       rst en tmc th  busy  req  en g ack te ev
        tbl.push_back(mk("rst0",    0, 1, 0, 4, 4'h0, 0,  1, 0, 0, 0, 0));
        tbl.push_back(mk("rst1",    0, 1, 0, 4, 4'h0, 0,  1, 0, 0, 0, 0));
        tbl.push_back(mk("busy",    1, 1, 0, 4, 4'h2, 0,  1, 0, 0, 0, 0));
        tbl.push_back(mk("idle1",   1, 1, 0, 4, 4'h0, 0,  1, 0, 0, 0, 0));
        tbl.push_back(mk("idle2",   1, 1, 0, 4, 4'h0, 0,  1, 0, 0, 0, 0));
        tbl.push_back(mk("idle3",   1, 1, 0, 4, 4'h0, 0,  1, 0, 0, 0, 0));
        tbl.push_back(mk("idle4",   1, 1, 0, 4, 4'h0, 0,  1, 0, 0, 0, 0));
        tbl.push_back(mk("gate",    1, 1, 0, 4, 4'h0, 0,  0, 1, 0, 0, 1));
        tbl.push_back(mk("off",     1, 1, 0, 4, 4'h0, 0,  0, 1, 0, 0, 1));
        tbl.push_back(mk("wake0",   1, 1, 0, 4, 4'h0, 1,  1, 0, 0, 0, 1));
        tbl.push_back(mk("wake1",   1, 1, 0, 4, 4'h0, 1,  1, 0, 0, 0, 1));
        tbl.push_back(mk("wake2",   1, 1, 0, 4, 4'h0, 1,  1, 0, 0, 0, 1));
        tbl.push_back(mk("wakeack", 1, 1, 0, 4, 4'h0, 1,  1, 0, 1, 0, 1));
        tbl.push_back(mk("reqdrop", 1, 1, 0, 4, 4'h0, 0,  1, 0, 0, 0, 1));
        tbl.push_back(mk("hy2",     1, 1, 0, 4, 4'h0, 0,  1, 0, 0, 0, 1));
        tbl.push_back(mk("hy3busy", 1, 1, 0, 4, 4'h8, 0,  1, 0, 0, 0, 1));
        tbl.push_back(mk("hy4",     1, 1, 0, 4, 4'h0, 0,  1, 0, 0, 0, 1));
        tbl.push_back(mk("hy5",     1, 1, 0, 4, 4'h0, 0,  1, 0, 0, 0, 1));
        tbl.push_back(mk("hy6",     1, 1, 0, 4, 4'h0, 0,  1, 0, 0, 0, 1));
        tbl.push_back(mk("hy7",     1, 1, 0, 4, 4'h0, 0,  1, 0, 0, 0, 1));
        tbl.push_back(mk("hyprio",  1, 1, 0, 4, 4'h1, 0,  1, 0, 0, 0, 1));
        tbl.push_back(mk("th0a",    1, 1, 0, 0, 4'h0, 0,  1, 0, 0, 0, 1));
        tbl.push_back(mk("th0b",    1, 1, 0, 0, 4'h0, 0,  0, 1, 0, 0, 2));
        tbl.push_back(mk("ovr0",    1, 0, 0, 0, 4'h0, 0,  1, 0, 0, 0, 2));
        tbl.push_back(mk("ovr1",    1, 0, 0, 0, 4'h0, 0,  1, 0, 0, 0, 2));
        tbl.push_back(mk("ovr2",    1, 0, 0, 0, 4'h0, 0,  1, 0, 0, 0, 2));
        tbl.push_back(mk("ovr3",    1, 0, 0, 0, 4'h0, 0,  1, 0, 0, 0, 2));
        tbl.push_back(mk("ovr4",    1, 0, 0, 0, 4'h0, 0,  1, 0, 0, 0, 2));
        tbl.push_back(mk("tmc0",    1, 0, 1, 0, 4'h0, 0,  1, 0, 0, 1, 2));
        tbl.push_back(mk("tmc1",    1, 1, 1, 0, 4'h0, 0,  1, 0, 0, 1, 2));
        tbl.push_back(mk("tmc2",    1, 1, 1, 0, 4'h0, 0,  1, 0, 0, 1, 2));
        tbl.push_back(mk("tmc3",    1, 1, 0, 0, 4'h0, 0,  1, 0, 0, 0, 2));
        tbl.push_back(mk("tmc4",    1, 1, 0, 0, 4'h0, 0,  0, 1, 0, 0, 3));
        tbl.push_back(mk("rstoff",  0, 1, 0, 0, 4'h0, 0,  1, 0, 0, 0, 0));
        tbl.push_back(mk("ackrun",  1, 1, 0, 0, 4'h4, 1,  1, 0, 1, 0, 0));
        tbl.push_back(mk("ackdrop", 1, 1, 0, 0, 4'h4, 0,  1, 0, 0, 0, 0));
        tbl.push_back(mk("live0",   1, 1, 0, 6, 4'h0, 0,  1, 0, 0, 0, 0));
        tbl.push_back(mk("live1",   1, 1, 0, 6, 4'h0, 0,  1, 0, 0, 0, 0));
        tbl.push_back(mk("live2",   1, 1, 0, 6, 4'h0, 0,  1, 0, 0, 0, 0));
        tbl.push_back(mk("live3",   1, 1, 0, 2, 4'h0, 0,  0, 1, 0, 0, 1));
        tbl.push_back(mk("rec0",    1, 1, 0, 2, 4'h1, 0,  1, 0, 0, 0, 1));
        tbl.push_back(mk("rec1",    1, 1, 0, 2, 4'h1, 0,  1, 0, 0, 0, 1));
        tbl.push_back(mk("rec2",    1, 1, 0, 2, 4'h1, 0,  1, 0, 0, 0, 1));

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

        // Wake request withdrawn after one cycle in OFF: warm-up completes, no ack.
        apply(mk("ab1", 1, 1, 0, 2, 4'h0, 0,  1, 0, 0, 0, 1));
        apply(mk("ab2", 1, 1, 0, 2, 4'h0, 0,  1, 0, 0, 0, 1));
        apply(mk("ab3", 1, 1, 0, 2, 4'h0, 0,  0, 1, 0, 0, 2));
        apply(mk("ab4", 1, 1, 0, 2, 4'h0, 1,  1, 0, 0, 0, 2));
        apply(mk("ab5", 1, 1, 0, 2, 4'h0, 0,  1, 0, 0, 0, 2));
        apply(mk("ab6", 1, 1, 0, 2, 4'h0, 0,  1, 0, 0, 0, 2));
        apply(mk("ab7", 1, 1, 0, 2, 4'h1, 0,  1, 0, 0, 0, 2));

        // Preload the event counter near the top, then gate repeatedly past saturation.
        @(negedge clk);
        busy = 4'h1; thresh = 8'd1;
        force dut.gate_events_q = 16'hFFFC;
        @(posedge clk);
        @(negedge clk);
        release dut.gate_events_q;
        ev_m = 16'hFFFC;
        for (int k = 0; k < 5; k++) begin
            apply(mk("sat_cool", 1, 1, 0, 1, 4'h0, 0,  1, 0, 0, 0, ev_m));
            if (ev_m != 16'hFFFF) ev_m = ev_m + 16'd1;
            apply(mk("sat_off",  1, 1, 0, 1, 4'h0, 0,  0, 1, 0, 0, ev_m));
            apply(mk("sat_w0",   1, 1, 0, 1, 4'h1, 0,  1, 0, 0, 0, ev_m));
            apply(mk("sat_w1",   1, 1, 0, 1, 4'h1, 0,  1, 0, 0, 0, ev_m));
            apply(mk("sat_run",  1, 1, 0, 1, 4'h1, 0,  1, 0, 0, 0, ev_m));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
